// File: rtl/bnn_stream_infer.sv
// Streaming binary neural network classifier with ROM-constant weights and valid/ready handshakes.
// Define BNN_STREAM_SCORE_EN to expose the winning class score on an extra output port.
module bnn_stream_infer #(
   parameter int FEAT_CNT   = 11,
   parameter int FEAT_BITS  = 4,
   parameter int HIDDEN_CNT = 40,
   parameter int CLASS_CNT  = 6,
   parameter int PAR        = 1,
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] W1 = '0,
   parameter logic [HIDDEN_CNT*(FEAT_BITS+$clog2(FEAT_CNT+1))-1:0] TH = '0,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [FEAT_BITS*FEAT_CNT-1:0]     features,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [$clog2(CLASS_CNT)-1:0]      prediction,
   output logic                              out_valid,
   input  logic                              out_ready
`ifdef BNN_STREAM_SCORE_EN
   ,
   output logic [$clog2(HIDDEN_CNT+1)-1:0]   score
`endif
);

   localparam int SW = FEAT_BITS + $clog2(FEAT_CNT + 1);
   localparam int NH = (HIDDEN_CNT + PAR - 1) / PAR;
   localparam int GW = (NH > 1) ? $clog2(NH) : 1;
   localparam int KW = $clog2(CLASS_CNT);
   localparam int CW = $clog2(HIDDEN_CNT + 1);
   localparam int JW = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
   localparam logic [FEAT_BITS-1:0] FMAX = '1;

   typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

   state_t                        state, state_nx;
   logic [FEAT_BITS*FEAT_CNT-1:0] feat_q;
   logic [HIDDEN_CNT-1:0]         hidden;
   logic [GW-1:0]                 group;
   logic [KW-1:0]                 k;
   logic [KW-1:0]                 best_idx;
   logic [CW-1:0]                 best_score;
   logic [CW-1:0]                 c_k;
   logic                          take;
   logic                          last_group, last_class;
   logic [PAR-1:0]                lane_ok, lane_h;
   logic [JW-1:0]                 lane_idx [PAR];

   assign last_group = (group == GW'(NH - 1));
   assign last_class = (k == KW'(CLASS_CNT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = HID;
         end
         HID:  if (last_group) state_nx = OUT;
         OUT:  if (last_class) state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Lanes past the last neuron are pointed at neuron 0 and flagged invalid so they never write.
   always_comb begin
      int                   j;
      logic [SW-1:0]        s;
      logic [FEAT_BITS-1:0] f;
      for (int l = 0; l < PAR; l++) begin
         j           = int'(group) * PAR + l;
         lane_ok[l]  = (j < HIDDEN_CNT);
         if (!lane_ok[l]) j = 0;
         lane_idx[l] = JW'(j);
         s = '0;
         for (int i = 0; i < FEAT_CNT; i++) begin
            f = feat_q[i*FEAT_BITS +: FEAT_BITS];
            s = s + SW'(W1[j*FEAT_CNT + i] ? f : FMAX - f);
         end
         lane_h[l] = (s >= TH[j*SW +: SW]);
      end
   end

   always_comb begin
      logic [HIDDEN_CNT-1:0] agree;
      agree = ~(W2[k*HIDDEN_CNT +: HIDDEN_CNT] ^ hidden);
      c_k   = '0;
      for (int j = 0; j < HIDDEN_CNT; j++) c_k = c_k + CW'(agree[j]);
      take  = (k == '0) || (c_k > best_score);
   end

   // NOTE: every register here is a plain flop vector, so clearing them all on reset is cheap and safe.
   always_ff @(posedge clk) begin
      if (rst) begin
         feat_q     <= '0;
         hidden     <= '0;
         group      <= '0;
         k          <= '0;
         best_idx   <= '0;
         best_score <= '0;
         prediction <= '0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               feat_q <= features;
               hidden <= '0;
               group  <= '0;
               k      <= '0;
            end
            HID: begin
               for (int l = 0; l < PAR; l++)
                  if (lane_ok[l]) hidden[lane_idx[l]] <= lane_h[l];
               group <= group + 1'b1;
            end
            OUT: begin
               if (take) begin
                  best_score <= c_k;
                  best_idx   <= k;
               end
               if (last_class) prediction <= take ? k : best_idx;
               k <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef BNN_STREAM_SCORE_EN
   assign score = best_score;
`endif

endmodule
